fifo_frame_reader: RTL and testbench
====================================

FIFO_FRAME_READER -- requirements
Module: fifo_frame_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the sample width.
REQ-002 SHALL have parameter FRAME_LEN, default 1024, the samples per FFT frame; legal range 2..2048.
REQ-003 SHALL have parameter LEVEL_WIDTH, default 12, the FIFO water-level width.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, with ports:
- rd_clk  in  1  sole clock (FFT domain)
- rd_rst  in  1  asynchronous, active-high reset
- enable  in  1  start/continue framing
- err_clr  in  1  clears underrun_err
- fifo_rd_en  out  1  FIFO read strobe
- fifo_rd_data  in  DATA_WIDTH  FIFO data, valid 1 cycle after fifo_rd_en
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_water_level  in  LEVEL_WIDTH  FIFO read-side occupancy
- m_tdata  out  DATA_WIDTH  output sample
- m_tvalid  out  1  output valid
- m_tready  in  1  downstream ready
- m_tlast  out  1  last sample of frame
- m_tuser  out  11  sample index within frame, 0..FRAME_LEN-1
- frame_busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse when the last sample is accepted
- underrun_err  out  1  sticky error flag

Function
REQ-005 SHALL implement states IDLE, ARM, STREAM and DRAIN.
REQ-006 IDLE: go to ARM when enable=1.
REQ-007 ARM: go to STREAM when fifo_rd_water_level >= FRAME_LEN; go to IDLE when enable=0.
REQ-008 STREAM: issue reads until FRAME_LEN reads have been issued, then go to DRAIN.
REQ-009 DRAIN: when the m_tlast beat is accepted, go to ARM if enable=1, else IDLE.
REQ-010 enable deasserting during STREAM/DRAIN SHALL NOT abort the frame; the frame always completes.
REQ-011 fifo_rd_en = (state==STREAM) & !fifo_empty & (issued<FRAME_LEN) & (occupancy<2).
- occupancy = entries held in the output buffer plus reads in flight.
REQ-012 SHALL contain a 2-entry output buffer capturing fifo_rd_data exactly one cycle after each fifo_rd_en.
- No sample may be dropped or duplicated under any m_tready pattern.
REQ-013 m_tvalid=1 whenever the buffer is non-empty.
- A beat transfers on m_tvalid & m_tready.
- m_tdata, m_tlast and m_tuser SHALL hold stable while m_tvalid=1 and m_tready=0.
REQ-014 m_tuser SHALL start at 0 for each frame and increment by 1 per accepted beat.
REQ-015 m_tlast=1 only on the beat with m_tuser = FRAME_LEN-1.
REQ-016 With m_tready held at 1 and the FIFO non-empty, the block SHALL sustain one beat per cycle after the first.
- Latency from entering STREAM to the first m_tvalid = 2 cycles.
REQ-017 frame_busy=1 in STREAM and DRAIN, 0 otherwise.
REQ-018 frame_done SHALL pulse high for exactly one cycle, in the cycle after the m_tlast beat transfers.
REQ-019 fifo_empty=1 in STREAM while issued<FRAME_LEN SHALL set underrun_err.
- The read is stalled, not skipped; the frame resumes when data returns.
REQ-020 underrun_err SHALL clear on err_clr=1.
- Simultaneous set and clear: set wins.
REQ-021 Counters SHALL be sized to reach FRAME_LEN without wrap.
- The issue counter resets to 0 on entry to STREAM.

Reset
REQ-022 While rd_rst=1, all state SHALL clear immediately: state=IDLE, fifo_rd_en=0, m_tvalid=0, m_tlast=0, m_tuser=0, m_tdata=0, frame_busy=0, frame_done=0, underrun_err=0, buffer empty.
REQ-023 Reset mid-frame SHALL discard the partial frame and in-flight reads.
- After release, the block starts from IDLE.
- No FIFO flush is performed by this block.

Verification (FRAME_LEN=8)
REQ-024 Level 7, enable=1 -> stays in ARM, no fifo_rd_en; level 8 -> STREAM, first m_tvalid 2 cycles later, 8 beats with m_tuser 0..7, m_tlast on 7, frame_done pulse.
REQ-025 m_tready toggling 1,0,0,1 with data 0x0001..0x0008 -> output sequence exactly 0x0001..0x0008, fifo_rd_en never asserted with occupancy=2.
REQ-026 fifo_empty forced high after 3 reads -> underrun_err=1, output stalls after beat 2, then resumes with beat 3 when empty drops; err_clr -> underrun_err=0.
REQ-027 enable dropped at beat 4 -> frame completes through beat 7, then IDLE, frame_busy=0.
REQ-028 rd_rst pulsed at beat 5 -> all outputs reach reset values the same cycle; with enable=1 and level 8 after release -> new frame with m_tuser starting at 0.

Source files
------------

// File: rtl/fifo_frame_reader.sv
// Pulls fixed-length frames out of a FIFO and streams them as AXI-Stream beats.
// A frame starts once the FIFO holds a full frame; a 2-entry skid buffer absorbs read latency.
module fifo_frame_reader #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAME_LEN   = 1024,
    parameter int LEVEL_WIDTH = 12
) (
    input  logic                   rd_clk,
    input  logic                   rd_rst,
    input  logic                   enable,
    input  logic                   err_clr,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_empty,
    input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
    output logic [DATA_WIDTH-1:0]  m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic [10:0]            m_tuser,
    output logic                   frame_busy,
    output logic                   frame_done,
    output logic                   underrun_err
);

    localparam int IW = $clog2(FRAME_LEN + 1);
    localparam logic [IW-1:0]          FL_CNT  = IW'(FRAME_LEN);
    localparam logic [IW-1:0]          FL_LAST = IW'(FRAME_LEN - 1);
    localparam logic [10:0]            IDX_END = 11'(FRAME_LEN - 1);
    localparam logic [LEVEL_WIDTH:0]   FL_LVL  = (LEVEL_WIDTH + 1)'(FRAME_LEN);

    typedef enum logic [1:0] {IDLE, ARM, STREAM, DRAIN} state_t;

    state_t                       state, state_nxt;
    logic [IW-1:0]                issued;
    logic [10:0]                  out_idx;
    logic                         inflight;
    logic [1:0][DATA_WIDTH-1:0]   obuf;
    logic                         wr_ptr, rd_ptr;
    logic [1:0]                   cnt;
    logic [1:0]                   occ;
    logic                         pop;
    logic                         enter_stream;

    assign m_tvalid   = (cnt != 2'd0);
    assign pop        = m_tvalid & m_tready;
    assign m_tdata    = obuf[rd_ptr];
    assign m_tuser    = out_idx;
    assign m_tlast    = m_tvalid & (out_idx == IDX_END);
    assign frame_busy = (state == STREAM) | (state == DRAIN);

    // Occupancy net of this cycle's pop, so a read can be issued into the slot
    // being freed; this is what lets the stream sustain one beat per cycle.
    assign occ = cnt + {1'b0, inflight} - {1'b0, pop};

    assign enter_stream = (state != STREAM) & (state_nxt == STREAM);

    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        case (state)
            IDLE:   if (enable) state_nxt = ARM;
            ARM: begin
                if (!enable)
                    state_nxt = IDLE;
                else if ({1'b0, fifo_rd_water_level} >= FL_LVL)
                    state_nxt = STREAM;
            end
            STREAM: begin
                fifo_rd_en = !fifo_empty & (issued < FL_CNT) & (occ < 2'd2);
                if (fifo_rd_en && issued == FL_LAST)
                    state_nxt = DRAIN;
            end
            DRAIN:  if (pop && m_tlast) state_nxt = enable ? ARM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state        <= IDLE;
            issued       <= '0;
            out_idx      <= '0;
            inflight     <= 1'b0;
            obuf         <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            cnt          <= 2'd0;
            frame_done   <= 1'b0;
            underrun_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= fifo_rd_en;
            if (inflight) begin
                obuf[wr_ptr] <= fifo_rd_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            cnt <= occ;

            if (enter_stream)
                issued <= '0;
            else if (fifo_rd_en)
                issued <= issued + 1'b1;

            if (enter_stream)
                out_idx <= '0;
            else if (pop)
                out_idx <= out_idx + 11'd1;

            frame_done <= pop & m_tlast;

            // Set wins over a simultaneous clear.
            if (state == STREAM && issued < FL_CNT && fifo_empty)
                underrun_err <= 1'b1;
            else if (err_clr)
                underrun_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Scoreboard bench for fifo_frame_reader with FRAME_LEN=8: a FIFO model feeds the DUT,
// expected beats are queued when data is loaded, and a monitor checks every accepted beat.
module tb_fifo_frame_reader;

    localparam int DW = 16;
    localparam int FL = 8;
    localparam int LW = 12;

    logic          rd_clk = 1'b0;
    logic          rd_rst = 1'b1;
    logic          enable = 1'b0;
    logic          err_clr = 1'b0;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_empty;
    logic [LW-1:0] level = '0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic [10:0]   m_tuser;
    logic          frame_busy;
    logic          frame_done;
    logic          underrun_err;

    fifo_frame_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .LEVEL_WIDTH(LW)) dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable), .err_clr(err_clr),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .fifo_rd_water_level(level), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .frame_busy(frame_busy), .frame_done(frame_done), .underrun_err(underrun_err)
    );

    always #5 rd_clk = ~rd_clk;

    typedef struct packed {
        logic [15:0] d;
        logic [10:0] idx;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, expv);
        end
    endtask

    // FIFO model: one-cycle read latency, fifo_empty from pointer equality.
    logic [15:0] fmem [256];
    logic [7:0]  wr_cnt = '0;
    logic [7:0]  rd_cnt = '0;
    bit          flush = 1'b0;
    assign fifo_empty = (wr_cnt == rd_cnt);

    always @(posedge rd_clk) begin
        if (flush)
            rd_cnt <= wr_cnt;
        else if (fifo_rd_en) begin
            fifo_rd_data <= fmem[rd_cnt];
            rd_cnt       <= rd_cnt + 8'd1;
        end
    end

    // Ready driver: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random.
    int ready_mode = 0;
    int rcyc = 0;
    always @(posedge rd_clk) begin
        #1;
        rcyc++;
        case (ready_mode)
            0: m_tready = 1'b1;
            1: m_tready = ((rcyc % 4) == 0) || ((rcyc % 4) == 3);
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: beats vs scoreboard, hold-while-stalled, occupancy bound, frame_done timing.
    int          n_rd = 0;
    int          n_beats = 0;
    int          beats_in_frame = 0;
    bit          exp_done = 1'b0;
    bit          prev_stall = 1'b0;
    logic [27:0] prev_out = '0;

    always @(negedge rd_clk) begin
        if (rd_rst) begin
            n_rd = 0; n_beats = 0; beats_in_frame = 0;
            exp_done = 1'b0; prev_stall = 1'b0;
        end else begin
            bit    pop;
            int    occ;
            beat_t e;
            if (exp_done || frame_done)
                chk("frame_done", 32'(frame_done), 32'(exp_done));
            exp_done = 1'b0;
            pop = m_tvalid && m_tready;
            if (prev_stall)
                chk("hold_stable", {3'b0, m_tvalid, m_tdata, m_tuser, m_tlast}, {4'b0001, prev_out});
            if (fifo_rd_en) begin
                occ = n_rd - n_beats - (pop ? 1 : 0);
                chk("occ_lt2", 32'(occ), 32'(occ < 2 ? occ : 1));
            end
            if (pop) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(m_tdata), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", 32'(m_tdata), 32'(e.d));
                    chk("tuser", 32'(m_tuser), 32'(e.idx));
                    chk("tlast", 32'(m_tlast), 32'(e.last));
                end
                beats_in_frame++;
                n_beats++;
                if (m_tlast) begin
                    exp_done = 1'b1;
                    beats_in_frame = 0;
                end
            end
            if (fifo_rd_en) n_rd++;
            prev_stall = m_tvalid && !m_tready;
            prev_out   = {m_tdata, m_tuser, m_tlast};
        end
    end

    task automatic load(input int n, input int first_idx, input bit inc, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            logic [15:0] d;
            d = inc ? base + 16'(i) : 16'($urandom);
            fmem[wr_cnt] = d;
            wr_cnt = wr_cnt + 8'd1;
            exp_q.push_back('{d: d, idx: 11'(first_idx + i), last: (first_idx + i) == FL - 1});
        end
    endtask

    task automatic start_frame();
        int i = 0;
        level = 12'd8;
        while (!frame_busy && i < 50) begin
            @(negedge rd_clk);
            i++;
        end
        chk("start_busy", 32'(frame_busy), 32'd1);
        level = 12'd0;
    endtask

    task automatic wait_done(input int bound);
        int i = 0;
        while (!frame_done && i < bound) begin
            @(negedge rd_clk);
            i++;
        end
        chk("done_seen", 32'(frame_done), 32'd1);
        @(negedge rd_clk);
    endtask

    task automatic wait_beats(input int n, input int bound);
        int i = 0;
        while (beats_in_frame < n && i < bound) begin
            @(negedge rd_clk);
            i++;
        end
        chk("beats_reached", 32'(beats_in_frame >= n), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"},  32'(fifo_rd_en),   32'd0);
        chk({tag, "_tvalid"}, 32'(m_tvalid),     32'd0);
        chk({tag, "_tlast"},  32'(m_tlast),      32'd0);
        chk({tag, "_tuser"},  32'(m_tuser),      32'd0);
        chk({tag, "_tdata"},  32'(m_tdata),      32'd0);
        chk({tag, "_busy"},   32'(frame_busy),   32'd0);
        chk({tag, "_done"},   32'(frame_done),   32'd0);
        chk({tag, "_err"},    32'(underrun_err), 32'd0);
    endtask

    initial begin
        int snap, t, tb_b, tv, td;

        repeat (2) @(negedge rd_clk);
        chk_reset_outputs("reset");
        rd_rst = 1'b0;

        // Level one short of a frame: must sit in ARM without reading.
        enable = 1'b1;
        level  = 12'd7;
        snap   = n_rd;
        repeat (10) @(negedge rd_clk);
        chk("arm_no_read", 32'(n_rd - snap), 32'd0);
        chk("arm_not_busy", 32'(frame_busy), 32'd0);

        // Full level: 2-cycle latency, then 8 back-to-back beats.
        load(8, 0, 1'b0, 16'h0);
        level = 12'd8;
        t = 0; tb_b = -1; tv = -1; td = -1;
        while (td < 0 && t < 100) begin
            @(negedge rd_clk);
            t++;
            if (frame_busy && tb_b < 0) begin tb_b = t; level = 12'd0; end
            if (m_tvalid && tv < 0) tv = t;
            if (frame_done) td = t;
        end
        chk("first_valid_latency", 32'(tv - tb_b), 32'd2);
        chk("full_rate", 32'(td - tv), 32'd8);
        @(negedge rd_clk);
        chk("f1_drained", 32'(exp_q.size()), 32'd0);

        // Ready pattern 1,0,0,1 with incrementing data.
        ready_mode = 1;
        load(8, 0, 1'b1, 16'h0001);
        start_frame();
        wait_done(200);
        chk("f2_drained", 32'(exp_q.size()), 32'd0);

        // Underrun after 3 reads; stall, then resume.
        ready_mode = 0;
        load(3, 0, 1'b0, 16'h0);
        start_frame();
        repeat (20) @(negedge rd_clk);
        chk("underrun_stall_beats", 32'(beats_in_frame), 32'd3);
        chk("underrun_set", 32'(underrun_err), 32'd1);
        chk("underrun_busy", 32'(frame_busy), 32'd1);
        load(5, 3, 1'b0, 16'h0);
        wait_done(100);
        chk("underrun_sticky", 32'(underrun_err), 32'd1);
        err_clr = 1'b1;
        @(negedge rd_clk);
        err_clr = 1'b0;
        chk("underrun_cleared", 32'(underrun_err), 32'd0);

        // Enable dropped mid-frame: frame completes, then idle.
        load(8, 0, 1'b0, 16'h0);
        start_frame();
        wait_beats(4, 100);
        enable = 1'b0;
        wait_done(100);
        chk("f4_drained", 32'(exp_q.size()), 32'd0);
        level = 12'd8;
        repeat (10) @(negedge rd_clk);
        chk("idle_after_disable", 32'(frame_busy), 32'd0);
        level = 12'd0;

        // Reset mid-frame, then a clean frame from index 0.
        enable = 1'b1;
        load(8, 0, 1'b0, 16'h0);
        start_frame();
        wait_beats(5, 100);
        #1 rd_rst = 1'b1;
        #1 chk_reset_outputs("midrst");
        exp_q.delete();
        flush = 1'b1;
        @(posedge rd_clk);
        @(posedge rd_clk);
        #1 flush = 1'b0;
        @(negedge rd_clk);
        rd_rst = 1'b0;
        load(8, 0, 1'b0, 16'h0);
        start_frame();
        wait_done(100);
        chk("f5_drained", 32'(exp_q.size()), 32'd0);

        // Random backpressure frames.
        ready_mode = 2;
        for (int f = 0; f < 3; f++) begin
            load(8, 0, 1'b0, 16'h0);
            start_frame();
            wait_done(300);
            chk("rand_drained", 32'(exp_q.size()), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
